// File: rtl/palette_ram_gen.sv
// rtl/palette_ram_gen.sv - parametrised PPU palette RAM with init sweep, backdrop mirroring,
// write-first render bypass and greyscale mask
module palette_ram_gen #(
  parameter int                ADDR_W     = 5,
  parameter int                DATA_W     = 6,
  parameter int                GROUP_W    = 2,
  parameter bit                MIRROR_EN  = 1'b1,
  parameter logic [DATA_W-1:0] FILL_VALUE = 6'h0F,
  parameter logic [DATA_W-1:0] GREY_MASK  = 6'h30
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ce,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_din,
  input  logic              cpu_we,
  input  logic              cpu_re,
  output logic [DATA_W-1:0] cpu_dout,
  output logic              cpu_valid,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_dout,
  input  logic              greyscale,
  output logic              busy
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [0:0]        state_q, state_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0] cpu_dout_q, rd_dout_q, rd_word_d;
  logic              cpu_valid_q;
  logic              run;
  logic              cpu_wr_ok, cpu_wr_acc, cpu_rd;
  logic [ADDR_W-1:0] cpu_phys, rd_phys;

  // Every entry whose low bits are zero aliases the shared backdrop at entry 0.
  function automatic logic [ADDR_W-1:0] phys(input logic [ADDR_W-1:0] a);
    if (MIRROR_EN && (a[GROUP_W-1:0] == '0)) return '0;
    return a;
  endfunction

  assign run      = (state_q == ST_RUN);
  assign cpu_phys = phys(cpu_addr);
  assign rd_phys  = phys(rd_addr);

  // Only sub-palette 0 (either half) may write the backdrop; other backdrop aliases are read-only.
  assign cpu_wr_ok  = !MIRROR_EN || (cpu_addr[GROUP_W-1:0] != '0) ||
                      (cpu_addr[ADDR_W-2:GROUP_W] == '0);
  assign cpu_wr_acc = run && ce && cpu_we && cpu_wr_ok;
  assign cpu_rd     = ce && cpu_re && !(run && cpu_we);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == ST_INIT) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == (ADDR_W+1)'(DEPTH - 1)) state_d = ST_RUN;
    end
  end

  always_comb begin
    rd_word_d = mem_q[rd_phys];
    if (cpu_wr_acc && (cpu_phys == rd_phys)) rd_word_d = cpu_din;
    if (greyscale) rd_word_d = rd_word_d & GREY_MASK;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_INIT;
      cnt_q       <= '0;
      cpu_dout_q  <= '0;
      cpu_valid_q <= 1'b0;
      rd_dout_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cpu_valid_q <= cpu_rd;
      if (cpu_rd) cpu_dout_q <= run ? mem_q[cpu_phys] : '0;
      if (!run) rd_dout_q <= '0;
      else if (ce) rd_dout_q <= rd_word_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      if (!run) mem_q[cnt_q[ADDR_W-1:0]] <= FILL_VALUE;
      else if (cpu_wr_acc) mem_q[cpu_phys] <= cpu_din;
    end
  end

  assign cpu_dout  = cpu_dout_q;
  assign cpu_valid = cpu_valid_q;
  assign rd_dout   = rd_dout_q;
  assign busy      = !run;

endmodule
